// File: rtl/bus_pkg.sv
// Shared types for the data-bus arbiter: master IDs, arbiter states and the
// per-master request bundle used by the forwarding mux.
package bus_pkg;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CORE = 1'b0;
  localparam master_id_t MASTER_DBG  = 1'b1;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
  } bus_req_t;

  // Read wins when a master raises both enables, so the write strobe is masked here.
  function automatic bus_req_t make_req(
    input logic [31:0] address,
    input logic [31:0] write_data,
    input logic [3:0]  byte_enable,
    input logic        read_enable,
    input logic        write_enable
  );
    bus_req_t r;
    r.address      = address;
    r.write_data   = write_data;
    r.byte_enable  = byte_enable;
    r.read_enable  = read_enable;
    r.write_enable = write_enable & ~read_enable;
    return r;
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of issuing-master IDs for reads still awaiting a slave response.
module arb_id_fifo
  import bus_pkg::*;
#(
  parameter int unsigned MAX_READS    = 4,
  parameter int unsigned ID_FIFO_BITS = $clog2(MAX_READS + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  master_id_t              din,
  output master_id_t              head,
  output logic                    full,
  output logic                    empty,
  output logic [ID_FIFO_BITS-1:0] count
);

  localparam int unsigned PTR_W = (MAX_READS > 1) ? $clog2(MAX_READS) : 1;

  master_id_t             mem [MAX_READS];
  logic       [PTR_W-1:0] wr_ptr;
  logic       [PTR_W-1:0] rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_READS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == ID_FIFO_BITS'(MAX_READS));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + ID_FIFO_BITS'(1);
        2'b01:   count <= count - ID_FIFO_BITS'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the data memory bus, with grant lock on
// slave stall and in-order routing of read responses to the issuing master.
module data_bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned MAX_READS    = 4,
  parameter int unsigned ID_FIFO_BITS = $clog2(MAX_READS + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_write_data,
  input  logic [3:0]  m0_byte_enable,
  input  logic        m0_read_enable,
  input  logic        m0_write_enable,
  output logic [31:0] m0_read_data,
  output logic        m0_wait_req,
  output logic        m0_valid,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_write_data,
  input  logic [3:0]  m1_byte_enable,
  input  logic        m1_read_enable,
  input  logic        m1_write_enable,
  output logic [31:0] m1_read_data,
  output logic        m1_wait_req,
  output logic        m1_valid,
  output logic [31:0] s_address,
  output logic [31:0] s_write_data,
  output logic [3:0]  s_byte_enable,
  output logic        s_read_enable,
  output logic        s_write_enable,
  input  logic [31:0] s_read_data,
  input  logic        s_wait_req,
  input  logic        s_valid
);

  bus_req_t   req_bus [2];
  logic [1:0] req;
  bus_req_t   granted;

  arb_state_t state;
  master_id_t last_grant;
  master_id_t lock_id;
  master_id_t grant_id;
  logic       grant_valid;
  logic       read_block;
  logic       accept;

  master_id_t              fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [ID_FIFO_BITS-1:0] outstanding;
  logic                    rsp_live;

  assign req_bus[0] = make_req(m0_address, m0_write_data, m0_byte_enable,
                               m0_read_enable, m0_write_enable);
  assign req_bus[1] = make_req(m1_address, m1_write_data, m1_byte_enable,
                               m1_read_enable, m1_write_enable);
  assign req[0] = m0_read_enable | m0_write_enable;
  assign req[1] = m1_read_enable | m1_write_enable;

  always_comb begin
    grant_id    = MASTER_CORE;
    grant_valid = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          grant_valid = |req;
          if (req[0] && req[1]) grant_id = ~last_grant;
          else if (req[1])      grant_id = MASTER_DBG;
          else                  grant_id = MASTER_CORE;
        end
        LOCKED: begin
          grant_id    = lock_id;
          grant_valid = req[lock_id];
        end
        default: begin
          grant_id    = MASTER_CORE;
          grant_valid = 1'b0;
        end
      endcase
    end
  end

  assign granted    = req_bus[grant_id];
  // Uses the registered count so a same-cycle response cannot unblock a read.
  assign read_block = grant_valid & granted.read_enable
                    & (outstanding == ID_FIFO_BITS'(MAX_READS));
  assign accept     = grant_valid & ~s_wait_req & ~read_block;

  always_comb begin
    s_address      = '0;
    s_write_data   = '0;
    s_byte_enable  = '0;
    s_read_enable  = 1'b0;
    s_write_enable = 1'b0;
    if (grant_valid) begin
      s_address      = granted.address;
      s_write_data   = granted.write_data;
      s_byte_enable  = granted.byte_enable;
      s_read_enable  = granted.read_enable & ~read_block;
      s_write_enable = granted.write_enable;
    end
  end

  always_comb begin
    m0_wait_req = 1'b1;
    m1_wait_req = 1'b1;
    if (!reset) begin
      if (!req[0])
        m0_wait_req = 1'b0;
      else if (grant_valid && grant_id == MASTER_CORE)
        m0_wait_req = s_wait_req | read_block;

      if (!req[1])
        m1_wait_req = 1'b0;
      else if (grant_valid && grant_id == MASTER_DBG)
        m1_wait_req = s_wait_req | read_block;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= MASTER_DBG;
      lock_id    <= MASTER_CORE;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (accept) begin
              last_grant <= grant_id;
            end else begin
              lock_id <= grant_id;
              state   <= LOCKED;
            end
          end
        end
        LOCKED: begin
          if (!grant_valid) begin
            state <= IDLE;
          end else if (accept) begin
            last_grant <= lock_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_id_fifo #(
    .MAX_READS    (MAX_READS),
    .ID_FIFO_BITS (ID_FIFO_BITS)
  ) u_id_fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept & granted.read_enable & ~fifo_full),
    .pop   (s_valid & ~fifo_empty),
    .din   (grant_id),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  assign rsp_live     = s_valid & ~fifo_empty & ~reset;
  assign m0_valid     = rsp_live & (fifo_head == MASTER_CORE);
  assign m1_valid     = rsp_live & (fifo_head == MASTER_DBG);
  assign m0_read_data = s_read_data;
  assign m1_read_data = s_read_data;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed and randomized checks of data_bus_arbiter against a queue-based
// transaction model of the arbitration and response-routing rules.
module tb_data_bus_arbiter;

  localparam int MAXR = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] m0_address = '0, m0_write_data = '0;
  logic [3:0]  m0_byte_enable = '0;
  logic        m0_read_enable = 1'b0, m0_write_enable = 1'b0;
  logic [31:0] m1_address = '0, m1_write_data = '0;
  logic [3:0]  m1_byte_enable = '0;
  logic        m1_read_enable = 1'b0, m1_write_enable = 1'b0;
  logic [31:0] s_read_data = '0;
  logic        s_wait_req = 1'b0, s_valid = 1'b0;

  logic [31:0] m0_read_data, m1_read_data, s_address, s_write_data;
  logic        m0_wait_req, m0_valid, m1_wait_req, m1_valid;
  logic [3:0]  s_byte_enable;
  logic        s_read_enable, s_write_enable;

  int checks = 0;
  int errors = 0;

  // Model state: pending read owners in issue order, lock status, last winner.
  bit q[$];
  bit m_locked = 1'b0;
  bit m_lock_id = 1'b0;
  bit m_last = 1'b1;
  bit e_gv, e_g, e_acc, e_rd_g;

  always #5 clock = ~clock;

  data_bus_arbiter #(.MAX_READS(MAXR)) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_write_data(m0_write_data),
    .m0_byte_enable(m0_byte_enable), .m0_read_enable(m0_read_enable),
    .m0_write_enable(m0_write_enable), .m0_read_data(m0_read_data),
    .m0_wait_req(m0_wait_req), .m0_valid(m0_valid),
    .m1_address(m1_address), .m1_write_data(m1_write_data),
    .m1_byte_enable(m1_byte_enable), .m1_read_enable(m1_read_enable),
    .m1_write_enable(m1_write_enable), .m1_read_data(m1_read_data),
    .m1_wait_req(m1_wait_req), .m1_valid(m1_valid),
    .s_address(s_address), .s_write_data(s_write_data),
    .s_byte_enable(s_byte_enable), .s_read_enable(s_read_enable),
    .s_write_enable(s_write_enable), .s_read_data(s_read_data),
    .s_wait_req(s_wait_req), .s_valid(s_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Mid-cycle: derive expected outputs from the model and compare all of them.
  task automatic settle();
    bit rd[2], wr[2], rq[2];
    logic [31:0] ad[2], wd[2];
    logic [3:0]  be[2];
    bit blk, w0, w1, v0, v1;
    @(negedge clock);
    rd[0] = m0_read_enable; wr[0] = m0_write_enable && !m0_read_enable;
    rd[1] = m1_read_enable; wr[1] = m1_write_enable && !m1_read_enable;
    rq[0] = m0_read_enable || m0_write_enable;
    rq[1] = m1_read_enable || m1_write_enable;
    ad[0] = m0_address; wd[0] = m0_write_data; be[0] = m0_byte_enable;
    ad[1] = m1_address; wd[1] = m1_write_data; be[1] = m1_byte_enable;
    e_g = 1'b0; e_gv = 1'b0;
    if (!reset) begin
      if (m_locked) begin
        e_g = m_lock_id; e_gv = rq[e_g];
      end else begin
        e_gv = rq[0] || rq[1];
        e_g  = (rq[0] && rq[1]) ? !m_last : rq[1];
      end
    end
    e_rd_g = rd[e_g];
    blk   = e_gv && rd[e_g] && (q.size() == MAXR);
    e_acc = e_gv && !s_wait_req && !blk;
    w0 = reset ? 1'b1 : !rq[0] ? 1'b0 : (e_gv && e_g == 1'b0) ? (s_wait_req || blk) : 1'b1;
    w1 = reset ? 1'b1 : !rq[1] ? 1'b0 : (e_gv && e_g == 1'b1) ? (s_wait_req || blk) : 1'b1;
    v0 = !reset && s_valid && q.size() > 0 && q[0] == 1'b0;
    v1 = !reset && s_valid && q.size() > 0 && q[0] == 1'b1;
    chk("s_address",     s_address,      e_gv ? ad[e_g] : 32'h0);
    chk("s_write_data",  s_write_data,   e_gv ? wd[e_g] : 32'h0);
    chk("s_byte_enable", {28'h0, s_byte_enable}, e_gv ? {28'h0, be[e_g]} : 32'h0);
    chk("s_read_enable", {31'h0, s_read_enable},  {31'h0, e_gv && rd[e_g] && !blk});
    chk("s_write_enable",{31'h0, s_write_enable}, {31'h0, e_gv && wr[e_g]});
    chk("m0_wait_req",   {31'h0, m0_wait_req}, {31'h0, w0});
    chk("m1_wait_req",   {31'h0, m1_wait_req}, {31'h0, w1});
    chk("m0_valid",      {31'h0, m0_valid},    {31'h0, v0});
    chk("m1_valid",      {31'h0, m1_valid},    {31'h0, v1});
    chk("m0_read_data",  m0_read_data, s_read_data);
    chk("m1_read_data",  m1_read_data, s_read_data);
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset) begin
      q.delete(); m_locked = 1'b0; m_last = 1'b1;
    end else begin
      if (s_valid && q.size() > 0) void'(q.pop_front());
      if (e_acc && e_rd_g) q.push_back(e_g);
      if (!m_locked) begin
        if (e_gv) begin
          if (e_acc) m_last = e_g;
          else begin m_locked = 1'b1; m_lock_id = e_g; end
        end
      end else if (!e_gv) m_locked = 1'b0;
      else if (e_acc) begin m_last = e_g; m_locked = 1'b0; end
    end
    #1;
  endtask

  task automatic idle_inputs();
    m0_read_enable = 0; m0_write_enable = 0; m1_read_enable = 0; m1_write_enable = 0;
    s_wait_req = 0; s_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    for (int unsigned i = 0; i < 2; i++) begin
      settle();
      chk("rst_m0_wait", {31'h0, m0_wait_req}, 32'h1);
      chk("rst_m1_wait", {31'h0, m1_wait_req}, 32'h1);
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ids[4];
    do_reset();

    // Single m0 read with a one-cycle-later response.
    m0_read_enable = 1; m0_address = 32'h1000;
    settle(); chk("t1_wait", {31'h0, m0_wait_req}, 32'h0);
    chk("t1_s_addr", s_address, 32'h1000); tick();
    m0_read_enable = 0; s_valid = 1; s_read_data = 32'hDEADBEEF;
    settle(); chk("t1_m0_valid", {31'h0, m0_valid}, 32'h1);
    chk("t1_m1_valid", {31'h0, m1_valid}, 32'h0);
    chk("t1_data", m0_read_data, 32'hDEADBEEF); tick();
    s_valid = 0;

    // Both masters write every cycle: alternation starting at m0.
    do_reset();
    m0_write_enable = 1; m0_address = 32'h100; m1_write_enable = 1; m1_address = 32'h200;
    for (int unsigned i = 0; i < 4; i++) begin
      settle(); chk("t2_alt", s_address, (i % 2 == 0) ? 32'h100 : 32'h200); tick();
    end

    // m1 locked through a 3-cycle stall while m0 waits.
    m0_write_enable = 0; m1_address = 32'h300; s_wait_req = 1;
    settle(); chk("t3_hold0", s_address, 32'h300); tick();
    m0_write_enable = 1; m0_address = 32'h400;
    for (int unsigned i = 0; i < 2; i++) begin
      settle(); chk("t3_hold", s_address, 32'h300);
      chk("t3_m0_wait", {31'h0, m0_wait_req}, 32'h1); tick();
    end
    s_wait_req = 0;
    settle(); chk("t3_m1_acc", {31'h0, m1_wait_req}, 32'h0); tick();
    settle(); chk("t3_m0_next", s_address, 32'h400); tick();
    idle_inputs();

    // Outstanding-read limit.
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      m0_read_enable = 1; m0_address = 32'h2000 + i * 4;
      settle(); chk("t4_rd_acc", {31'h0, m0_wait_req}, 32'h0); tick();
    end
    m0_read_enable = 0; m1_write_enable = 1; m1_address = 32'h5000;
    settle(); chk("t4_wr_ok", {31'h0, s_write_enable}, 32'h1);
    chk("t4_wr_wait", {31'h0, m1_wait_req}, 32'h0); tick();
    m1_write_enable = 0; m0_read_enable = 1; m0_address = 32'h2010;
    settle(); chk("t4_blk_wait", {31'h0, m0_wait_req}, 32'h1);
    chk("t4_blk_re", {31'h0, s_read_enable}, 32'h0); tick();
    s_valid = 1; s_read_data = 32'h11;
    settle(); chk("t4_pop_blk", {31'h0, m0_wait_req}, 32'h1); tick();
    s_valid = 0;
    settle(); chk("t4_unblk", {31'h0, s_read_enable}, 32'h1); tick();
    m0_read_enable = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      s_valid = 1; s_read_data = 32'h20 + i;
      settle(); chk("t4_drain", {31'h0, m0_valid}, 32'h1); tick();
    end
    s_valid = 0;

    // Interleaved owners m0, m1, m1, m0.
    do_reset();
    ids[0] = 0; ids[1] = 1; ids[2] = 1; ids[3] = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      m0_read_enable = !ids[i]; m1_read_enable = ids[i];
      m0_address = 32'h3000 + i; m1_address = 32'h4000 + i;
      settle(); tick();
    end
    m0_read_enable = 0; m1_read_enable = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      s_valid = 1; s_read_data = 32'hA + i;
      settle();
      chk("t5_m0_valid", {31'h0, m0_valid}, {31'h0, !ids[i]});
      chk("t5_m1_valid", {31'h0, m1_valid}, {31'h0, ids[i]});
      tick();
    end
    s_valid = 0;

    // Reset with two reads in flight discards their responses.
    m0_read_enable = 1; settle(); tick(); m0_read_enable = 0;
    m1_read_enable = 1; settle(); tick(); m1_read_enable = 0;
    reset = 1; settle(); tick(); reset = 0;
    for (int unsigned i = 0; i < 2; i++) begin
      s_valid = 1; s_read_data = 32'hBAD0 + i;
      settle(); chk("t6_no_m0", {31'h0, m0_valid}, 32'h0);
      chk("t6_no_m1", {31'h0, m1_valid}, 32'h0); tick();
    end
    s_valid = 0;
    m0_write_enable = 1; m0_address = 32'h600; m1_write_enable = 1; m1_address = 32'h700;
    settle(); chk("t6_m0_first", s_address, 32'h600); tick();
    idle_inputs();

    // Randomized traffic against the model.
    for (int unsigned n = 0; n < 3000; n++) begin
      int unsigned k0, k1;
      reset = ($urandom_range(0, 199) == 0);
      k0 = $urandom_range(0, 9); k1 = $urandom_range(0, 9);
      m0_read_enable  = (k0 inside {[1:3], 9});
      m0_write_enable = (k0 inside {[4:6], 9});
      m1_read_enable  = (k1 inside {[1:3], 9});
      m1_write_enable = (k1 inside {[4:6], 9});
      m0_address = $urandom; m0_write_data = $urandom; m0_byte_enable = 4'($urandom);
      m1_address = $urandom; m1_write_data = $urandom; m1_byte_enable = 4'($urandom);
      s_wait_req  = ($urandom_range(0, 2) == 0);
      s_valid     = (q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s_read_data = $urandom;
      settle(); tick();
    end
    reset = 0; idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Shares one data memory bus slave between two masters: m0 is the core data port, m1 is the debug/DMA port.
- Arbitrates round-robin and holds the grant while the slave stalls.
- Tracks up to MAX_READS outstanding reads and routes each in-order read response back to its issuing master.
- Sits between the core/debug logic and the data memory bus.

Parameters:
- MAX_READS, 4, maximum accepted reads awaiting s_valid; must be >=1.
- ID_FIFO_BITS, $clog2(MAX_READS+1), width of the outstanding counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  32  master 0 byte address
- m0_write_data  in  32  master 0 store data
- m0_byte_enable  in  4  master 0 byte lanes
- m0_read_enable  in  1  master 0 read request
- m0_write_enable  in  1  master 0 write request
- m0_read_data  out  32  read response data (shared with m1)
- m0_wait_req  out  1  master 0 stall; request not accepted this cycle
- m0_valid  out  1  read response for master 0
- m1_*  same eight signals, same widths and meaning, for master 1
- s_address / s_write_data / s_byte_enable / s_read_enable / s_write_enable  out  32/32/4/1/1  to slave bus
- s_read_data  in  32  slave response data
- s_wait_req  in  1  slave stall
- s_valid  in  1  slave read response strobe

Behaviour:
- Request and acceptance:
  - req_k = mk_read_enable | mk_write_enable.
  - Both enables high on one master is illegal; read takes precedence.
  - A transfer is accepted when the granted master's request is forwarded and s_wait_req=0 with no read block.
- Read block: granted request is a read and outstanding == MAX_READS. While blocked, s_read_enable is forced 0 and the master sees wait_req=1. A pop in the same cycle does not unblock.
- Writes are never blocked by the outstanding count. Writes produce no response.
- FSM states: IDLE, LOCKED.
  - IDLE: grant is combinational.
    - Only one master requesting: it wins.
    - Both requesting: the master != last_grant wins.
    - On acceptance: last_grant <= winner, stay IDLE.
    - Winner stalled (s_wait_req=1 or read block): lock_id <= winner, go LOCKED.
  - LOCKED: grant = lock_id regardless of the other master.
    - On acceptance: last_grant <= lock_id, go IDLE.
    - If the locked master drops its request (protocol violation): go IDLE with no transfer.
- Forwarding: the granted master's address, data, byte_enable and enables drive s_*. With no grant, s_read_enable = s_write_enable = 0 and other s_* = 0.
- Master wait_req:
  - Non-granted master with req=1: wait_req=1.
  - Granted master: wait_req = s_wait_req | read_block.
  - Master with req=0: wait_req=0.
- ID FIFO: depth MAX_READS, 1-bit entries.
  - Push the granted ID on read acceptance.
  - Pop on s_valid.
  - Push and pop in the same cycle: count unchanged, order preserved.
- Response routing:
  - mk_valid = s_valid & (head == k).
  - m0_read_data = m1_read_data = s_read_data; the data is meaningful only with the matching valid.
- s_valid with an empty FIFO is ignored: no valid out, count stays 0.
- Slave timing: the slave responds >=1 cycle after acceptance. Same-cycle response is unsupported.
- Reset:
  - state = IDLE, last_grant = 1 (so m0 wins the first tie), FIFO empty, outstanding = 0.
  - While reset=1: s_read_enable = s_write_enable = 0, both wait_req = 1, both valid = 0.
  - Responses in flight when reset is asserted are discarded.
- Latency: zero added cycles on request and response paths; all routing is combinational from registered state.

Decomposition:
- Package bus_pkg:
  - typedef master_id_t (1 bit), constants MASTER_CORE = 0, MASTER_DBG = 1.
  - typedef arb_state_t {IDLE, LOCKED}.
  - typedef bus_req_t struct {address, write_data, byte_enable, read_enable, write_enable} for the forwarding mux.
- Sub-module arb_id_fifo (push, pop, din, head, full, empty, count), parameterised by MAX_READS, with pointer wrap-around.

Test Plan:
- Only m0 reads 0x1000, s_wait_req=0; s_valid one cycle later with 0xDEADBEEF -> m0_wait_req=0 on the request cycle, m0_valid=1 with 0xDEADBEEF, m1_valid=0.
- Both masters write every cycle -> grants alternate m0, m1, m0, m1; the first grant after reset goes to m0.
- m1 granted and s_wait_req=1 for 3 cycles while m0 also requests -> s_address holds m1's address all 3 cycles; m0 granted in the cycle after m1 is accepted.
- With the slave withholding s_valid, issue 4 m0 reads then a 5th -> 5th sees wait_req=1 and s_read_enable=0; a write from m1 is still accepted; the first s_valid unblocks the read the following cycle.
- Interleaved reads m0, m1, m1, m0 with responses A, B, C, D -> valid order is m0:A, m1:B, m1:C, m0:D.
- Assert reset with 2 reads outstanding, then s_valid pulses -> no mk_valid; outstanding = 0; next arbitration favours m0.
